quad_decoder: RTL and testbench

- Upstream feeder for the up/down `counter`. Converts a two-phase quadrature input pair (rotary encoder or jog buttons) into single-cycle `inc`/`dec` strobes that drive the counter's `inc`/`dec` ports directly.
- Synchronises the raw asynchronous inputs, glitch-filters them, and tracks the Gray-code phase.
- Emits one step per valid phase transition and flags illegal double transitions.

---
 rtl/quad_pkg.sv | 26 ++
 rtl/sync_filter.sv | 54 +++++
 rtl/quad_decoder.sv | 88 ++++++++
 tb/tb_quad_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared phase encodings, direction type and Gray-code step helper
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_FWD,
        DIR_REV,
        DIR_ERR
    } dir_t;

    // Forward successor in the cycle 00 -> 01 -> 11 -> 10 -> 00, phase = {A,B}.
    function automatic logic [1:0] next_fwd(input logic [1:0] phase);
        case (phase)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

endpackage

// File: rtl/sync_filter.sv
// rtl/sync_filter.sv - two-flop synchroniser plus joint stability filter with accept strobe
module sync_filter #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] held,
    input  logic             armed,
    output logic [WIDTH-1:0] stable,
    output logic             accept
);

    localparam logic [7:0] FILT_MAX = 8'(FILT_LEN);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] cand_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = 8'd1;
        end else if (cnt_q < FILT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // The consumer updates `held` on the accept edge, so this drops after one cycle.
    // Before the consumer is armed, any settled value is offered so it can prime.
    assign stable = cand_q;
    assign accept = (cnt_q == FILT_MAX) && (!armed || (cand_q != held));

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature input to registered inc/dec/err strobes for the up/down counter
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned INC_SIZE = 1,
    parameter int unsigned DEC_SIZE = 1,
    parameter int unsigned INC_STEP = 1,
    parameter int unsigned DEC_STEP = 1,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_in,
    input  logic                b_in,
    output logic [INC_SIZE-1:0] inc,
    output logic [DEC_SIZE-1:0] dec,
    output logic                err
);

    localparam logic [INC_SIZE-1:0] INC_VAL = INC_SIZE'(INC_STEP);
    localparam logic [DEC_SIZE-1:0] DEC_VAL = DEC_SIZE'(DEC_STEP);

    logic [1:0]          stable;
    logic                accept;
    logic [1:0]          phase_q;
    logic                primed_q;
    logic [INC_SIZE-1:0] inc_q;
    logic [DEC_SIZE-1:0] dec_q;
    logic                err_q;
    dir_t                dir;

    sync_filter #(
        .WIDTH    (2),
        .FILT_LEN (FILT_LEN)
    ) u_sync_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    ({a_in, b_in}),
        .held   (phase_q),
        .armed  (primed_q),
        .stable (stable),
        .accept (accept)
    );

    always_comb begin
        dir = DIR_NONE;
        if (stable == next_fwd(phase_q)) begin
            dir = DIR_FWD;
        end else if (next_fwd(stable) == phase_q) begin
            dir = DIR_REV;
        end else if (stable != phase_q) begin
            dir = DIR_ERR;
        end
    end

    // Every accepted value is adopted as the new phase, including illegal jumps,
    // so the decoder resynchronises instead of staying stuck on a bad reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_00;
            primed_q <= 1'b0;
            inc_q    <= '0;
            dec_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            inc_q <= '0;
            dec_q <= '0;
            err_q <= 1'b0;
            if (accept) begin
                phase_q  <= stable;
                primed_q <= 1'b1;
                if (primed_q) begin
                    case (dir)
                        DIR_FWD: inc_q <= INC_VAL;
                        DIR_REV: dec_q <= DEC_VAL;
                        DIR_ERR: err_q <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign inc = inc_q;
    assign dec = dec_q;
    assign err = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder
module tb_quad_decoder;
    import quad_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_in;
    logic       b_in;
    logic [0:0] inc;
    logic [0:0] dec;
    logic       err;

    always #5 clk = ~clk;

    quad_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .inc   (inc),
        .dec   (dec),
        .err   (err)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int inc_cnt = 0;
    int dec_cnt = 0;
    int err_cnt = 0;
    int wide_cnt = 0;
    int bad_cnt = 0;
    logic [7:0] count = 8'd0;
    logic inc_p = 1'b0;
    logic dec_p = 1'b0;
    logic err_p = 1'b0;
    logic [1:0] cur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor and downstream 8-bit counter model fed by the strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (inc != 0) begin
                inc_cnt++;
                count = count + 8'd1;
                if (inc != 1) bad_cnt++;
            end
            if (dec != 0) begin
                dec_cnt++;
                count = count - 8'd1;
                if (dec != 1) bad_cnt++;
            end
            if (err) err_cnt++;
            if (inc != 0 && dec != 0) bad_cnt++;
            if ((inc != 0 && inc_p) || (dec != 0 && dec_p) || (err && err_p)) wide_cnt++;
        end
        inc_p = (inc != 0);
        dec_p = (dec != 0);
        err_p = err;
    end

    task automatic clear_mon();
        inc_cnt  = 0;
        dec_cnt  = 0;
        err_cnt  = 0;
        wide_cnt = 0;
        bad_cnt  = 0;
    endtask

    task automatic drive(input logic [1:0] ab, input int hold);
        @(negedge clk);
        {a_in, b_in} = ab;
        repeat (hold) @(negedge clk);
    endtask

    function automatic logic [1:0] prev_of(input logic [1:0] p);
        logic [1:0] r;
        r = PH_00;
        for (int i = 0; i < 4; i++) begin
            if (next_fwd(2'(i)) == p) r = 2'(i);
        end
        return r;
    endfunction

    task automatic expect_counts(input string tag, input int e_inc, input int e_dec, input int e_err);
        check_eq({tag, "_inc"}, inc_cnt, e_inc);
        check_eq({tag, "_dec"}, dec_cnt, e_dec);
        check_eq({tag, "_err"}, err_cnt, e_err);
        check_eq({tag, "_wide"}, wide_cnt, 0);
        check_eq({tag, "_bad"}, bad_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        a_in  = 1'b1;
        b_in  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_inc", inc, 0);
        check_eq("rst_dec", dec, 0);
        check_eq("rst_err", err, 0);

        // 1: silent priming from 11
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        expect_counts("prime11", 0, 0, 0);

        // re-prime from 00
        rst_n = 1'b0;
        a_in  = 1'b0;
        b_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        clear_mon();

        // 2: forward sequence, first step with latency check
        @(negedge clk);
        {a_in, b_in} = PH_01;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("lat_edge5", inc, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("lat_edge6", inc, 1);
        repeat (8) @(negedge clk);
        drive(PH_11, 10);
        drive(PH_10, 10);
        drive(PH_00, 10);
        expect_counts("fwd", 4, 0, 0);

        // 3: reverse sequence
        clear_mon();
        drive(PH_10, 10);
        drive(PH_11, 10);
        drive(PH_01, 10);
        drive(PH_00, 10);
        expect_counts("rev", 0, 4, 0);

        // 4: 2-cycle glitch on A
        clear_mon();
        @(negedge clk);
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        repeat (20) @(negedge clk);
        expect_counts("glitch", 0, 0, 0);

        // 5: double transition, then a legal forward step
        clear_mon();
        drive(PH_11, 10);
        expect_counts("dbl", 0, 0, 1);
        clear_mon();
        drive(PH_10, 10);
        expect_counts("after_dbl", 1, 0, 0);

        // 6: chained counter model, 255 up then 255 down
        clear_mon();
        count = 8'd0;
        cur   = PH_10;
        for (int i = 0; i < 255; i++) begin
            cur = next_fwd(cur);
            drive(cur, 8);
        end
        check_eq("cnt_up", count, 255);
        for (int i = 0; i < 255; i++) begin
            cur = prev_of(cur);
            drive(cur, 8);
        end
        check_eq("cnt_down", count, 0);
        expect_counts("chain", 255, 255, 0);

        // reset while a strobe is high
        @(negedge clk);
        cur = next_fwd(cur);
        {a_in, b_in} = cur;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
        check_eq("pre_rst_inc", inc, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_inc", inc, 0);
        check_eq("mid_rst_dec", dec, 0);
        check_eq("mid_rst_err", err, 0);
        repeat (3) @(negedge clk);
        clear_mon();
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        expect_counts("post_rst", 0, 0, 0);
        cur = next_fwd(cur);
        drive(cur, 10);
        expect_counts("fresh", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
